// File: rtl/gesture_pkg.sv
// Shared types and helpers for the gesture persistence filter.
// Holds the FSM state encoding and the confidence saturation function.
package gesture_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        EMIT     = 2'd2,
        COOLDOWN = 2'd3
    } gf_state_t;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Shift the peak magnitude down, then clamp to the largest
    // value representable in 'bits' bits.
    function automatic logic [31:0] sat_conf(
        input logic [63:0] peak,
        input int unsigned shift,
        input int unsigned bits
    );
        logic [63:0] shifted;
        logic [63:0] limit;
        shifted = peak >> shift;
        limit   = (64'd1 << bits) - 64'd1;
        return (shifted > limit) ? limit[31:0] : shifted[31:0];
    endfunction

endpackage

// File: rtl/gf_down_timer.sv
// Loadable down-counter used for the track timeout and the cooldown.
// Load wins over tick; expired is high while the count sits at zero.
module gf_down_timer #(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_tick,
    output logic o_expired
);

    localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = (CYCLES > 0) ? W'(CYCLES - 1) : '0;

    logic [W-1:0] r_cnt;

    // Reload on request, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/gesture_persistence_filter.sv
// Debounces classifier results: a class is emitted only after a run of
// consecutive matching hits, then held on valid/ready with a cooldown.
module gesture_persistence_filter
    import gesture_pkg::*;
#(
    parameter int unsigned NUM_CLASSES  = 4,
    parameter int unsigned CLASS_BITS   = 2,
    parameter int unsigned MAG_BITS     = 18,
    parameter int unsigned PERSIST_MIN  = 2,
    parameter int unsigned CONF_BITS    = 4,
    parameter int unsigned CONF_SHIFT   = 4,
    parameter int unsigned COOLDOWN_CYC = 0,
    parameter int unsigned TIMEOUT_CYC  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cls_valid,
    input  logic                  cls_pass,
    input  logic [CLASS_BITS-1:0] cls_id,
    input  logic [MAG_BITS-1:0]   mag_x,
    input  logic [MAG_BITS-1:0]   mag_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CLASS_BITS-1:0] out_id,
    output logic [CONF_BITS-1:0]  out_conf,
    output logic [7:0]            out_run,
    output logic [7:0]            drop_count,
    output logic [1:0]            dbg_state
);

    gf_state_t             r_state;
    logic [CLASS_BITS-1:0] r_cand;
    logic [7:0]            r_run;
    logic [MAG_BITS-1:0]   r_peak;
    logic                  r_out_valid;
    logic [CLASS_BITS-1:0] r_out_id;
    logic [CONF_BITS-1:0]  r_out_conf;
    logic [7:0]            r_out_run;
    logic [7:0]            r_drop;

    logic                  w_hit;
    logic                  w_same;
    logic                  w_confirm;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_to_exp;
    logic                  w_cd_exp;
    logic                  w_timeout;
    logic [MAG_BITS-1:0]   w_m;
    logic [MAG_BITS-1:0]   w_peak_max;
    logic [7:0]            w_run_inc;
    logic [CONF_BITS-1:0]  w_conf_new;
    logic [CONF_BITS-1:0]  w_conf_trk;

    assign w_hit      = cls_valid & cls_pass
                      & (32'(cls_id) < NUM_CLASSES);
    assign w_m        = (mag_x > mag_y) ? mag_x : mag_y;
    assign w_same     = (cls_id == r_cand);
    assign w_run_inc  = r_run + 8'd1;
    assign w_confirm  = (32'(w_run_inc) >= PERSIST_MIN);
    assign w_peak_max = (w_m > r_peak) ? w_m : r_peak;
    assign w_conf_new = CONF_BITS'(sat_conf(64'(w_m),
                                            CONF_SHIFT, CONF_BITS));
    assign w_conf_trk = CONF_BITS'(sat_conf(64'(w_peak_max),
                                            CONF_SHIFT, CONF_BITS));
    assign w_accept   = r_out_valid & out_ready;
    assign w_drop     = cls_valid
                      & ((r_state == EMIT) | (r_state == COOLDOWN));
    assign w_timeout  = (TIMEOUT_CYC != 0) & (r_state == TRACK)
                      & ~cls_valid & w_to_exp;

    gf_down_timer #(
        .CYCLES (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_load    (cls_valid),
        .i_tick    ((r_state == TRACK) & ~cls_valid),
        .o_expired (w_to_exp)
    );

    gf_down_timer #(
        .CYCLES (COOLDOWN_CYC)
    ) u_cooldown (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_tick    (r_state == COOLDOWN),
        .o_expired (w_cd_exp)
    );

    // Run tracking FSM with registered outputs and the drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cand      <= '0;
            r_run       <= '0;
            r_peak      <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_conf  <= '0;
            r_out_run   <= '0;
            r_drop      <= '0;
        end else begin
            if (w_drop && (r_drop != DROP_MAX)) begin
                r_drop <= r_drop + 8'd1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_cand <= cls_id;
                        r_run  <= 8'd1;
                        r_peak <= w_m;
                        if (PERSIST_MIN <= 1) begin
                            r_state     <= EMIT;
                            r_out_valid <= 1'b1;
                            r_out_id    <= cls_id;
                            r_out_conf  <= w_conf_new;
                            r_out_run   <= 8'd1;
                        end else begin
                            r_state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (w_hit && w_same) begin
                        r_run  <= w_run_inc;
                        r_peak <= w_peak_max;
                        if (w_confirm) begin
                            r_state     <= EMIT;
                            r_out_valid <= 1'b1;
                            r_out_id    <= r_cand;
                            r_out_conf  <= w_conf_trk;
                            r_out_run   <= w_run_inc;
                        end
                    end else if (w_hit) begin
                        r_cand <= cls_id;
                        r_run  <= 8'd1;
                        r_peak <= w_m;
                    end else if (cls_valid || w_timeout) begin
                        r_run   <= '0;
                        r_peak  <= '0;
                        r_state <= IDLE;
                    end
                end
                EMIT: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_run       <= '0;
                        r_peak      <= '0;
                        r_state     <= (COOLDOWN_CYC > 0) ? COOLDOWN : IDLE;
                    end
                end
                COOLDOWN: begin
                    if (w_cd_exp) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_id     = r_out_id;
    assign out_conf   = r_out_conf;
    assign out_run    = r_out_run;
    assign drop_count = r_drop;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gesture_persistence_filter.sv
// Scoreboard bench for gesture_persistence_filter: a run/queue reference
// model predicts outputs, a negedge monitor compares what the DUT presents.
module tb_gesture_persistence_filter;

    localparam int NC = 4;
    localparam int CB = 3;
    localparam int MB = 18;
    localparam int PM = 3;
    localparam int CW = 4;
    localparam int CS = 4;
    localparam int CD = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cls_valid = 1'b0;
    logic          cls_pass = 1'b0;
    logic [CB-1:0] cls_id = '0;
    logic [MB-1:0] mag_x = '0;
    logic [MB-1:0] mag_y = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [CB-1:0] out_id;
    logic [CW-1:0] out_conf;
    logic [7:0]    out_run;
    logic [7:0]    drop_count;
    logic [1:0]    dbg_state;

    gesture_persistence_filter #(
        .NUM_CLASSES  (NC),
        .CLASS_BITS   (CB),
        .MAG_BITS     (MB),
        .PERSIST_MIN  (PM),
        .CONF_BITS    (CW),
        .CONF_SHIFT   (CS),
        .COOLDOWN_CYC (CD),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cls_valid  (cls_valid),
        .cls_pass   (cls_pass),
        .cls_id     (cls_id),
        .mag_x      (mag_x),
        .mag_y      (mag_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_conf   (out_conf),
        .out_run    (out_run),
        .drop_count (drop_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a run is the list of magnitudes of consecutive
    // matching hits; time is tracked as an edge index.
    typedef struct {
        int id;
        int conf;
        int run;
    } exp_t;

    exp_t exp_q[$];
    int   streak[$];
    int   streak_id   = 0;
    int   m_cyc       = 0;
    int   m_last      = 0;
    int   m_cool_last = -1;
    bit   m_hold      = 1'b0;
    int   m_drops     = 0;
    bit   m_flush     = 1'b0;
    bit   vis_valid   = 1'b0;
    int   vis_drops   = 0;
    int   n_push      = 0;
    int   n_pop       = 0;
    int   n_flush     = 0;
    bit   mon_en      = 1'b0;

    task automatic model_drop();
        if (m_drops < 255) m_drops++;
    endtask

    task automatic model_apply(input bit r, input bit v, input bit p,
                               input int id, input int mag,
                               input bit rdy);
        m_cyc++;
        if (r) begin
            streak.delete();
            m_hold      = 1'b0;
            m_drops     = 0;
            m_cool_last = m_cyc;
            m_flush     = 1'b1;
            return;
        end
        if (m_hold) begin
            if (v) model_drop();
            if (rdy) begin
                m_hold      = 1'b0;
                m_cool_last = m_cyc + CD;
            end
            return;
        end
        if (m_cyc <= m_cool_last) begin
            if (v) model_drop();
            return;
        end
        if (!v) begin
            if (streak.size() > 0 && (m_cyc - m_last) >= TO)
                streak.delete();
            return;
        end
        m_last = m_cyc;
        if (!p || id >= NC) begin
            streak.delete();
            return;
        end
        if (streak.size() > 0 && streak_id != id) streak.delete();
        streak_id = id;
        streak.push_back(mag);
        if (streak.size() >= PM) begin
            int pk;
            exp_t e;
            pk = 0;
            foreach (streak[i]) if (streak[i] > pk) pk = streak[i];
            pk = pk >> CS;
            if (pk > (1 << CW) - 1) pk = (1 << CW) - 1;
            e.id   = id;
            e.conf = pk;
            e.run  = streak.size();
            exp_q.push_back(e);
            n_push++;
            m_hold = 1'b1;
            streak.delete();
        end
    endtask

    // One clock: publish the model view for this cycle, predict the
    // next edge, drive the DUT and return 1ns after that edge.
    task automatic step(input bit r, input bit v, input bit p,
                        input int id, input int mx, input int my,
                        input bit rdy);
        if (m_flush) begin
            n_flush += exp_q.size();
            exp_q.delete();
            m_flush = 1'b0;
        end
        vis_valid = m_hold;
        vis_drops = m_drops;
        model_apply(r, v, p, id, (mx > my) ? mx : my, rdy);
        rst       = r;
        cls_valid = v;
        cls_pass  = p;
        cls_id    = CB'(id);
        mag_x     = MB'(mx);
        mag_y     = MB'(my);
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input int id, input int m, input bit rdy = 1'b1);
        step(1'b0, 1'b1, 1'b1, id, m, $urandom_range(0, m), rdy);
    endtask

    task automatic fail_res();
        step(1'b0, 1'b1, 1'b0, 0, 10, 0, 1'b1);
    endtask

    task automatic idle(input int n, input bit rdy = 1'b1);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0, 0, rdy);
    endtask

    // Monitor: compares presented outputs against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("out_valid", out_valid, vis_valid);
                chk("drop_count", drop_count, vis_drops);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got id %0d expected none",
                                 out_id);
                    end else begin
                        chk("out_id", out_id, exp_q[0].id);
                        chk("out_conf", out_conf, exp_q[0].conf);
                        chk("out_run", out_run, exp_q[0].run);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            n_pop++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int id;
        int mx;
        int my;
        bit p;
        bit rdy;

        @(posedge clk);
        #1;
        repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_conf", out_conf, 0);
        chk("rst_out_run", out_run, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_state", dbg_state, 0);
        mon_en = 1'b1;

        hit(2, 40);
        hit(2, 80);
        chk("s1_early", out_valid, 0);
        hit(2, 300);
        chk("s1_latency", out_valid, 1);
        chk("s1_id", out_id, 2);
        chk("s1_conf", out_conf, 15);
        chk("s1_run", out_run, 3);
        idle(12);

        hit(1, 'h50);
        hit(1, 'h50);
        hit(3, 'h50);
        hit(3, 'h50);
        hit(3, 'h50);
        chk("s2_id", out_id, 3);
        chk("s2_conf", out_conf, 5);
        idle(12);

        hit(0, 60);
        hit(0, 60);
        fail_res();
        chk("s3_fail_state", dbg_state, 0);
        hit(2, 70);
        hit(2, 70);
        hit(5, 70);
        chk("s3_badid_state", dbg_state, 0);
        hit(2, 70);
        chk("s3_restart_state", dbg_state, 1);
        fail_res();
        chk("s3_no_out", out_valid, 0);

        hit(1, 100);
        hit(1, 100);
        idle(63);
        chk("to_before", dbg_state, 1);
        idle(1);
        chk("to_expire", dbg_state, 0);
        hit(1, 100);
        chk("to_no_out", out_valid, 0);
        idle(64);
        hit(1, 100);
        hit(1, 100);
        idle(63);
        hit(1, 100);
        chk("to_edge_out", out_valid, 1);
        chk("to_edge_id", out_id, 1);
        idle(12);

        hit(0, 100, 1'b0);
        hit(0, 100, 1'b0);
        hit(0, 100, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 2 || i == 5 || i == 9)
                step(1'b0, 1'b1, 1'b1, 1, 50, 0, 1'b0);
            else
                idle(1, 1'b0);
        end
        chk("stall_valid", out_valid, 1);
        chk("stall_drops", drop_count, 3);
        idle(1);
        repeat (8) hit(3, 200);
        chk("cd_drops", drop_count, 11);
        chk("cd_state", dbg_state, 0);
        hit(3, 200);
        hit(3, 200);
        hit(3, 200);
        chk("cd_restart_out", out_valid, 1);
        chk("cd_restart_conf", out_conf, 12);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        chk("rst_emit_valid", out_valid, 0);
        chk("rst_emit_drop", drop_count, 0);
        chk("rst_emit_state", dbg_state, 0);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            k   = $urandom_range(0, 99);
            rdy = ($urandom_range(0, 9) < 7);
            if (k == 0) begin
                idle($urandom_range(60, 68), rdy);
            end else if (k == 1) begin
                step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
            end else if (k < 50) begin
                idle(1, rdy);
            end else begin
                if ($urandom_range(0, 3) == 0) id = $urandom_range(0, 7);
                else id = $urandom_range(0, 1);
                p  = ($urandom_range(0, 9) < 8);
                mx = $urandom_range(0, 400);
                my = $urandom_range(0, 400);
                step(1'b0, 1'b1, p, id, mx, my, rdy);
            end
        end
        idle(80);

        chk("queue_empty", exp_q.size(), 0);
        chk("scoreboard_balance", n_pop + n_flush, n_push);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
